// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: song word layout, end marker,
// FSM state encoding and the OneHot note constants used by the note path.
package song_sequencer_pkg;

    localparam int NOTE_LSB = 0;
    localparam int NOTE_MSB = 9;
    localparam int DUR_LSB  = 10;
    localparam int DUR_MSB  = 15;

    localparam int NOTE_W = NOTE_MSB - NOTE_LSB + 1;
    localparam int DUR_W  = DUR_MSB - DUR_LSB + 1;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    // A word whose note and duration fields are both zero terminates the song.
    localparam logic [DUR_MSB:NOTE_LSB] SONG_END = '0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } seqState;

    localparam logic [NOTE_W-1:0] DO   = 10'b0000000001;
    localparam logic [NOTE_W-1:0] RE   = 10'b0000000010;
    localparam logic [NOTE_W-1:0] MI   = 10'b0000000100;
    localparam logic [NOTE_W-1:0] FA   = 10'b0000001000;
    localparam logic [NOTE_W-1:0] SO   = 10'b0000010000;
    localparam logic [NOTE_W-1:0] LA   = 10'b0000100000;
    localparam logic [NOTE_W-1:0] SI   = 10'b0001000000;
    localparam logic [NOTE_W-1:0] HIDO = 10'b0010000000;
    localparam logic [NOTE_W-1:0] HIMI = 10'b0100000000;
    localparam logic [NOTE_W-1:0] HISO = 10'b1000000000;

    function automatic logic isMultiHot(input logic [NOTE_W-1:0] note);
        return (note & (note - NOTE_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/song_sequencer_unit_tick.sv
// Duration-unit prescaler: pulses tick on the last cycle of every
// TICKS-cycle unit while enabled; clr restarts the unit from zero.
module unit_tick #(
    parameter int unsigned TICKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] countReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countReg <= '0;
        end else if (clr) begin
            countReg <= '0;
        end else if (en) begin
            countReg <= (countReg == LAST) ? '0 : countReg + CW'(1);
        end
    end

    assign tick = en && (countReg == LAST);

endmodule

// File: rtl/song_sequencer.sv
// Auto-play sequencer: reads one song slot from the song RAM word by word and
// drives the one-hot note path with per-note durations and articulation gaps.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int unsigned TICKS_PER_UNIT = 12_500_000,
    parameter int unsigned GAP_TICKS      = 1_000_000,
    parameter int unsigned SLOT_BITS      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [2:0]        song_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [NOTE_W-1:0] note_onehot,
    output logic              note_valid,
    output logic              busy,
    output logic              done,
    output logic              note_err
);

    localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

    seqState           stateReg, stateNext;
    logic [ADDR_W-1:0] addrReg, addrNext;
    logic [DUR_W-1:0]  durReg, durNext;
    logic [GW-1:0]     gapReg, gapNext;
    logic [NOTE_W-1:0] curNoteReg, curNoteNext;
    logic              errReg, errNext;
    logic [NOTE_W-1:0] noteReg;
    logic              validReg, busyReg, doneReg;

    logic              tickEn, tickClr, unitTick;
    logic              wordFinished;

    logic [NOTE_W-1:0] wordNote;
    logic [DUR_W-1:0]  wordDur;
    logic              isEnd, lastOffset;
    logic              unusedBits;

    assign wordNote   = mem_rdata[NOTE_MSB:NOTE_LSB];
    assign wordDur    = mem_rdata[DUR_MSB:DUR_LSB];
    assign isEnd      = (mem_rdata[DUR_MSB:NOTE_LSB] == SONG_END);
    assign lastOffset = &addrReg[SLOT_BITS-1:0];
    assign unusedBits = ^mem_rdata[DATA_W-1:DUR_MSB+1];

    unit_tick #(
        .TICKS (TICKS_PER_UNIT)
    ) unitTickInst (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tickEn),
        .clr   (tickClr),
        .tick  (unitTick)
    );

    always_comb begin
        stateNext    = stateReg;
        addrNext     = addrReg;
        durNext      = durReg;
        gapNext      = gapReg;
        curNoteNext  = curNoteReg;
        errNext      = errReg;
        tickEn       = 1'b0;
        tickClr      = 1'b0;
        wordFinished = 1'b0;

        if (stop) begin
            stateNext = IDLE;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (start) begin
                        stateNext = FETCH;
                        addrNext  = ADDR_W'(song_sel) << SLOT_BITS;
                        errNext   = 1'b0;
                    end
                end
                FETCH: stateNext = LATCH;
                LATCH: begin
                    tickClr = 1'b1;
                    if (isEnd) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = PLAY;
                        durNext   = (wordDur == '0) ? DUR_W'(1) : wordDur;
                        // Multi-hot words are played as rests and flag an error.
                        if (isMultiHot(wordNote)) begin
                            curNoteNext = '0;
                            errNext     = 1'b1;
                        end else begin
                            curNoteNext = wordNote;
                        end
                    end
                end
                PLAY: begin
                    if (!pause) begin
                        tickEn = 1'b1;
                        if (unitTick) begin
                            durNext = durReg - DUR_W'(1);
                            if (durReg == DUR_W'(1)) begin
                                if (GAP_TICKS == 0) begin
                                    wordFinished = 1'b1;
                                end else begin
                                    stateNext = GAP;
                                    gapNext   = '0;
                                end
                            end
                        end
                    end
                end
                GAP: begin
                    if (!pause) begin
                        if (gapReg == GAP_LAST) begin
                            wordFinished = 1'b1;
                        end else begin
                            gapNext = gapReg + GW'(1);
                        end
                    end
                end
                DONE: stateNext = IDLE;
                default: stateNext = IDLE;
            endcase

            // The address stays inside the slot: the last offset ends the song.
            if (wordFinished) begin
                if (lastOffset) begin
                    stateNext = DONE;
                end else begin
                    stateNext = FETCH;
                    addrNext  = addrReg + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg   <= IDLE;
            addrReg    <= '0;
            durReg     <= '0;
            gapReg     <= '0;
            curNoteReg <= '0;
            errReg     <= 1'b0;
            noteReg    <= '0;
            validReg   <= 1'b0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            addrReg    <= addrNext;
            durReg     <= durNext;
            gapReg     <= gapNext;
            curNoteReg <= curNoteNext;
            errReg     <= errNext;
            // Outputs are registered from the next state; pause silences the next cycle.
            noteReg    <= (stateNext == PLAY && !pause) ? curNoteNext : '0;
            validReg   <= (stateNext == PLAY) && !pause && (curNoteNext != '0);
            busyReg    <= (stateNext != IDLE);
            doneReg    <= (stateNext == DONE);
        end
    end

    assign mem_addr    = addrReg;
    assign mem_we      = 1'b0;
    assign note_onehot = noteReg;
    assign note_valid  = validReg;
    assign busy        = busyReg;
    assign done        = doneReg;
    assign note_err    = errReg;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed scenarios plus randomized songs checked
// against a timeline model built from the song words.
module tb_song_sequencer;
    import song_sequencer_pkg::*;

    localparam int TPU  = 4;
    localparam int GAPT = 2;
    localparam int SB   = 10;
    localparam int MAXC = 9000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic [2:0]  songSel = 3'd0;
    logic [13:0] memAddr;
    logic        memWe;
    logic [31:0] memRdata;
    logic [9:0]  noteOnehot;
    logic        noteValid, busy, done, noteErr;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram [0:16383];

    logic [9:0]  obsNote  [0:MAXC];
    logic        obsValid [0:MAXC];
    logic        obsDone  [0:MAXC];
    logic        obsBusy  [0:MAXC];
    logic        obsErr   [0:MAXC];
    logic [13:0] obsAddr  [0:MAXC];

    logic [9:0]  expNote  [0:MAXC];
    logic        expValid [0:MAXC];
    logic        expDone  [0:MAXC];
    logic        expBusy  [0:MAXC];
    logic        expErr   [0:MAXC];
    logic [13:0] expAddr  [0:MAXC];
    int          expDoneCyc;

    always #5 clk = ~clk;

    always @(posedge clk) memRdata <= ram[memAddr];

    song_sequencer #(
        .TICKS_PER_UNIT (TPU),
        .GAP_TICKS      (GAPT),
        .SLOT_BITS      (SB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .song_sel    (songSel),
        .mem_addr    (memAddr),
        .mem_we      (memWe),
        .mem_rdata   (memRdata),
        .note_onehot (noteOnehot),
        .note_valid  (noteValid),
        .busy        (busy),
        .done        (done),
        .note_err    (noteErr)
    );

    function automatic logic [31:0] mkWord(input logic [9:0] note, input int dur);
        logic [31:0] w;
        w = 32'h0;
        w[9:0]   = note;
        w[15:10] = 6'(dur);
        return w;
    endfunction

    // Pulse start (edge 0), then record cycles 1..nCyc sampled mid-cycle.
    task automatic run_song(input int sel, input int nCyc, input int pK, input int pL, input int stopAt);
        @(negedge clk);
        songSel = 3'(sel);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= nCyc; c++) begin
            pause = (pL > 0 && c >= pK && c < pK + pL);
            stop  = (c == stopAt);
            obsNote[c]  = noteOnehot;
            obsValid[c] = noteValid;
            obsDone[c]  = done;
            obsBusy[c]  = busy;
            obsErr[c]   = noteErr;
            obsAddr[c]  = memAddr;
            @(negedge clk);
        end
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    // Timeline per word: fetch t, latch t+1, play D*TPU cycles, GAPT silent.
    // A pause window starting inside a play stretches it and silences the note.
    task automatic build_model(input int sel, input int pK, input int pL);
        int t, off, base, a, b, d, errFrom;
        logic [31:0] w;
        logic [9:0] n;
        logic silent;
        base = sel * 1024;
        t = 1;
        off = 0;
        errFrom = MAXC + 1;
        for (int c = 0; c <= MAXC; c++) begin
            expNote[c] = '0; expValid[c] = 1'b0; expDone[c] = 1'b0;
            expBusy[c] = 1'b0; expErr[c] = 1'b0; expAddr[c] = '0;
        end
        while (1) begin
            w = ram[base + off];
            if (w[15:0] == 16'h0) begin
                for (int c = t; c <= t + 3; c++) expAddr[c] = 14'(base + off);
                expDoneCyc = t + 2;
                break;
            end
            n = w[9:0];
            d = (w[15:10] == 6'd0) ? 1 : int'(w[15:10]);
            if ($countones(n) > 1) begin
                if (errFrom > MAXC) errFrom = t + 2;
                n = '0;
            end
            a = t + 2;
            b = a + d * TPU - 1;
            if (pL > 0 && pK >= a && pK <= b) b = b + pL;
            for (int c = a; c <= b; c++) begin
                silent = (pL > 0 && c > pK && c <= pK + pL);
                expNote[c]  = silent ? 10'd0 : n;
                expValid[c] = !silent && (n != 10'd0);
            end
            for (int c = t; c <= b + GAPT; c++) expAddr[c] = 14'(base + off);
            t = b + GAPT + 1;
            if (off == 1023) begin
                expAddr[t] = 14'(base + off);
                expAddr[t + 1] = 14'(base + off);
                expDoneCyc = t;
                break;
            end
            off++;
        end
        expDone[expDoneCyc] = 1'b1;
        for (int c = 1; c <= expDoneCyc + 1; c++) begin
            expBusy[c] = (c <= expDoneCyc);
            expErr[c]  = (c >= errFrom);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || noteValid !== 1'b0 || noteErr !== 1'b0 || noteOnehot !== 10'd0 || memAddr !== 14'd0 || memWe !== 1'b0)
            begin errors++; $display("FAIL reset_state: busy=%b done=%b valid=%b err=%b note=%b addr=%0d we=%b, want all zero", busy, done, noteValid, noteErr, noteOnehot, memAddr, memWe); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || memAddr !== 14'd0)
            begin errors++; $display("FAIL reset_release: busy=%b addr=%0d, want 0 and 0", busy, memAddr); end
        @(negedge clk);
        songSel = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (noteValid !== 1'b1 || noteOnehot !== HIDO)
            begin errors++; $display("FAIL reset_pre_play: valid=%b note=%b, want 1 and %b", noteValid, noteOnehot, HIDO); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || noteValid !== 1'b0 || noteOnehot !== 10'd0 || memAddr !== 14'd0 || done !== 1'b0)
            begin errors++; $display("FAIL reset_mid_play: busy=%b valid=%b note=%b addr=%0d done=%b, want all zero", busy, noteValid, noteOnehot, memAddr, done); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || memAddr !== 14'd0 || noteValid !== 1'b0)
            begin errors++; $display("FAIL reset_after_play: busy=%b addr=%0d valid=%b, want 0", busy, memAddr, noteValid); end
        $display("reset: mid-play reset cleared outputs");
    endtask

    task automatic test_normal;
        logic [9:0] en;
        logic ev;
        run_song(0, 26, 0, 0, 0);
        for (int c = 1; c <= 24; c++) begin
            ev = (c >= 3 && c <= 10) || (c >= 15 && c <= 18);
            en = (c >= 3 && c <= 10) ? HIDO : ((c >= 15 && c <= 18) ? HISO : 10'd0);
            checks++;
            if (obsValid[c] !== ev || obsNote[c] !== en || obsDone[c] !== (c == 23) || obsBusy[c] !== (c <= 23)) begin
                errors++;
                $display("FAIL normal cycle %0d: valid=%b note=%b done=%b busy=%b, want valid=%b note=%b done=%b busy=%b",
                         c, obsValid[c], obsNote[c], obsDone[c], obsBusy[c], ev, en, (c == 23), (c <= 23));
                break;
            end
        end
        checks++;
        if (obsAddr[21] !== 14'd2 || obsAddr[1] !== 14'd0)
            begin errors++; $display("FAIL normal_end_addr: first=%0d end=%0d, want 0 and 2", obsAddr[1], obsAddr[21]); end
        checks++;
        if (obsErr[1] !== 1'b0)
            begin errors++; $display("FAIL normal_err_clear: err=%b, want 0", obsErr[1]); end
        $display("normal: slot 0 HIDO d2, HISO d1 played");
    endtask

    task automatic test_pause;
        int nHido, doneAt, nDone;
        run_song(0, 32, 5, 5, 0);
        nHido = 0; doneAt = 0; nDone = 0;
        for (int c = 1; c <= 32; c++) begin
            if (obsValid[c] === 1'b1 && obsNote[c] === HIDO) nHido++;
            if (obsDone[c] === 1'b1) begin nDone++; if (doneAt == 0) doneAt = c; end
        end
        checks++;
        if (nHido !== 8)
            begin errors++; $display("FAIL pause_hido_len: %0d valid cycles, want 8", nHido); end
        checks++;
        if (doneAt !== 28 || nDone !== 1)
            begin errors++; $display("FAIL pause_done: done at %0d (%0d pulses), want 28 (1)", doneAt, nDone); end
        checks++;
        if (obsValid[6] !== 1'b0 || obsValid[10] !== 1'b0 || obsValid[11] !== 1'b1 || obsNote[11] !== HIDO)
            begin errors++; $display("FAIL pause_window: v6=%b v10=%b v11=%b n11=%b, want 0 0 1 %b", obsValid[6], obsValid[10], obsValid[11], obsNote[11], HIDO); end
        $display("pause: 5-cycle pause during HIDO, done at %0d", doneAt);
    endtask

    task automatic test_stop_start;
        int nDone;
        run_song(0, 30, 0, 0, 6);
        checks++;
        if (obsValid[6] !== 1'b1 || obsBusy[7] !== 1'b0 || obsValid[7] !== 1'b0 || obsNote[7] !== 10'd0)
            begin errors++; $display("FAIL stop_play: v6=%b busy7=%b v7=%b n7=%b, want 1 0 0 0", obsValid[6], obsBusy[7], obsValid[7], obsNote[7]); end
        nDone = 0;
        for (int c = 1; c <= 30; c++) if (obsDone[c] === 1'b1) nDone++;
        checks++;
        if (nDone !== 0)
            begin errors++; $display("FAIL stop_no_done: %0d done pulses, want 0", nDone); end
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0)
            begin errors++; $display("FAIL start_stop_idle: busy=%b, want 0", busy); end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL start_stop_later: busy=%b done=%b, want 0 0", busy, done); end
        $display("stop: abort in PLAY and start+stop in IDLE");
    endtask

    task automatic test_rest_error;
        int nValid;
        ram[2048] = mkWord(10'd0, 1);
        ram[2049] = mkWord(10'b0000000011, 1);
        ram[2050] = mkWord(HIDO, 1);
        ram[2051] = 32'h5A5A_0000;
        run_song(2, 30, 0, 0, 0);
        nValid = 0;
        for (int c = 3; c <= 14; c++) if (obsValid[c] !== 1'b0 || obsNote[c] !== 10'd0) nValid++;
        checks++;
        if (nValid !== 0)
            begin errors++; $display("FAIL rest_silent: %0d sounding cycles in rest/error words, want 0", nValid); end
        checks++;
        if (obsErr[10] !== 1'b0 || obsErr[6] !== 1'b0)
            begin errors++; $display("FAIL rest_no_err: err6=%b err10=%b, want 0 0", obsErr[6], obsErr[10]); end
        checks++;
        if (obsErr[11] !== 1'b1 || obsErr[27] !== 1'b1)
            begin errors++; $display("FAIL multi_hot_err: err11=%b err27=%b, want 1 1", obsErr[11], obsErr[27]); end
        checks++;
        if (obsValid[19] !== 1'b1 || obsNote[22] !== HIDO || obsDone[27] !== 1'b1)
            begin errors++; $display("FAIL rest_after: v19=%b n22=%b d27=%b, want 1 %b 1", obsValid[19], obsNote[22], obsDone[27], HIDO); end
        repeat (3) @(negedge clk);
        checks++;
        if (noteErr !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL err_sticky: err=%b busy=%b, want 1 0", noteErr, busy); end
        run_song(0, 3, 0, 0, 0);
        checks++;
        if (obsErr[1] !== 1'b0)
            begin errors++; $display("FAIL err_cleared_by_start: err=%b, want 0", obsErr[1]); end
        repeat (30) @(negedge clk);
        $display("rest/error: rest silent, multi-hot flagged until next start");
    endtask

    task automatic test_random;
        int sel, nWords, kind, dur, pK, pL;
        logic [9:0] n;
        logic [31:0] junk;
        for (int it = 0; it < 10; it++) begin
            sel = $urandom_range(3, 7);
            nWords = $urandom_range(1, 6);
            for (int k = 0; k < nWords; k++) begin
                kind = $urandom_range(0, 9);
                dur = $urandom_range(0, 3);
                n = 10'd1 << $urandom_range(0, 9);
                if (kind == 7) n = 10'd0;
                if (kind == 8) n = n | (10'd1 << ((n == 10'd1) ? 1 : 0));
                if (n == 10'd0 && dur == 0) dur = 1;
                junk = $urandom;
                ram[sel * 1024 + k] = {junk[15:0], 6'(dur), n};
            end
            junk = $urandom;
            ram[sel * 1024 + nWords] = {junk[31:16], 16'h0};
            pL = (it % 2 == 1) ? $urandom_range(1, 4) : 0;
            pK = $urandom_range(3, 6);
            build_model(sel, pK, pL);
            run_song(sel, expDoneCyc + 1, pK, pL, 0);
            for (int c = 1; c <= expDoneCyc + 1; c++) begin
                checks++;
                if (obsNote[c] !== expNote[c] || obsValid[c] !== expValid[c] || obsDone[c] !== expDone[c] ||
                    obsBusy[c] !== expBusy[c] || obsErr[c] !== expErr[c] || obsAddr[c] !== expAddr[c]) begin
                    errors++;
                    $display("FAIL random[%0d] cycle %0d: note=%b v=%b d=%b busy=%b err=%b addr=%0d, want note=%b v=%b d=%b busy=%b err=%b addr=%0d",
                             it, c, obsNote[c], obsValid[c], obsDone[c], obsBusy[c], obsErr[c], obsAddr[c],
                             expNote[c], expValid[c], expDone[c], expBusy[c], expErr[c], expAddr[c]);
                    break;
                end
            end
            $display("random[%0d]: sel=%0d words=%0d pause=%0d@%0d done@%0d", it, sel, nWords, pL, pK, expDoneCyc);
        end
    endtask

    task automatic test_slot_end;
        int doneAt, nDone;
        logic [13:0] maxAddr, minAddr;
        for (int i = 0; i < 1024; i++)
            ram[1024 + i] = {16'hABCD, mkWord((i % 4 == 0) ? 10'd0 : (10'd1 << (i % 10)), 1)};
        ram[2048] = mkWord(HISO, 1);
        run_song(1, 8200, 0, 0, 0);
        doneAt = 0; nDone = 0; maxAddr = 14'd0; minAddr = 14'h3FFF;
        for (int c = 1; c <= 8200; c++) begin
            if (obsDone[c] === 1'b1) begin nDone++; if (doneAt == 0) doneAt = c; end
            if (obsAddr[c] > maxAddr) maxAddr = obsAddr[c];
            if (obsAddr[c] < minAddr) minAddr = obsAddr[c];
        end
        checks++;
        if (obsAddr[1] !== 14'd1024)
            begin errors++; $display("FAIL slot_base: first addr=%0d, want 1024", obsAddr[1]); end
        checks++;
        if (maxAddr !== 14'd2047 || minAddr !== 14'd1024)
            begin errors++; $display("FAIL slot_range: addr %0d..%0d, want 1024..2047", minAddr, maxAddr); end
        checks++;
        if (doneAt !== 8193 || nDone !== 1)
            begin errors++; $display("FAIL slot_done: done at %0d (%0d pulses), want 8193 (1)", doneAt, nDone); end
        checks++;
        if (obsNote[8187] !== 10'd8 || obsBusy[8194] !== 1'b0)
            begin errors++; $display("FAIL slot_last_word: note=%b busy=%b, want 0000001000 0", obsNote[8187], obsBusy[8194]); end
        $display("slot end: slot 1 full, done at %0d, max addr %0d", doneAt, maxAddr);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        ram[0] = mkWord(HIDO, 2);
        ram[1] = mkWord(HISO, 1);
        ram[2] = 32'h0;
        ram[3] = mkWord(MI, 3);
        test_reset();
        test_normal();
        test_pause();
        test_stop_start();
        test_rest_error();
        test_random();
        test_slot_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
